// File: rtl/memory_arbiter_if.sv
// Shared memory port bundle: fetch and data requesters on one side,
// the single-ported memory on the other.
interface memory_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              d_rd;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic              if_done;
   logic              d_done;
   logic [DATA_W-1:0] rdata;
   logic              stall;
   logic              err;

   modport slave (
      input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata,
      input  mem_ready, mem_rdata,
      output mem_addr, mem_wdata, mem_rd, mem_wr,
      output if_done, d_done, rdata, stall, err
   );

   modport master (
      output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata,
      output mem_ready, mem_rdata,
      input  mem_addr, mem_wdata, mem_rd, mem_wr,
      input  if_done, d_done, rdata, stall, err
   );
endinterface

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter for one shared memory port: data first,
// bounded fetch starvation, access timeout with sticky error.
module memory_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic             clk,
   input  logic             rst,
   memory_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D, DONE} state_t;

   state_t            state, nextState;
   logic [SW-1:0]     starveCnt, starveNext;
   logic [TW-1:0]     toCnt, toNext;
   logic [ADDR_W-1:0] addrQ, addrNext;
   logic [DATA_W-1:0] wdataQ, wdataNext;
   logic [DATA_W-1:0] rdataQ, rdataNext;
   logic              isWr, isWrNext;
   logic              gntD, gntDNext;
   logic              errQ, errNext;
   logic              dReq, starved, inAcc;

   assign dReq    = bus.d_rd | bus.d_wr;
   assign starved = bus.if_req && (starveCnt == SW'(STARVE_MAX));
   assign inAcc   = (state == ACC_IF) || (state == ACC_D);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         starveCnt <= '0;
         toCnt     <= '0;
         addrQ     <= '0;
         wdataQ    <= '0;
         rdataQ    <= '0;
         isWr      <= 1'b0;
         gntD      <= 1'b0;
         errQ      <= 1'b0;
      end else begin
         state     <= nextState;
         starveCnt <= starveNext;
         toCnt     <= toNext;
         addrQ     <= addrNext;
         wdataQ    <= wdataNext;
         rdataQ    <= rdataNext;
         isWr      <= isWrNext;
         gntD      <= gntDNext;
         errQ      <= errNext;
      end
   end

   always_comb begin
      nextState  = state;
      starveNext = starveCnt;
      toNext     = toCnt;
      addrNext   = addrQ;
      wdataNext  = wdataQ;
      rdataNext  = rdataQ;
      isWrNext   = isWr;
      gntDNext   = gntD;
      errNext    = errQ;
      unique case (state)
         IDLE: begin
            toNext = '0;
            if (!bus.if_req) starveNext = '0;
            if (dReq && !starved) begin
               nextState = ACC_D;
               gntDNext  = 1'b1;
               addrNext  = bus.d_addr;
               wdataNext = bus.d_wdata;
               // a read+write collision is served as a write
               isWrNext  = bus.d_wr;
               if (bus.d_rd && bus.d_wr) errNext = 1'b1;
               if (bus.if_req) starveNext = starveCnt + 1'b1;
            end else if (bus.if_req) begin
               nextState  = ACC_IF;
               gntDNext   = 1'b0;
               addrNext   = bus.if_addr;
               wdataNext  = '0;
               isWrNext   = 1'b0;
               starveNext = '0;
            end
         end
         ACC_IF, ACC_D: begin
            if (bus.mem_ready) begin
               nextState = DONE;
               if (!isWr) rdataNext = bus.mem_rdata;
            end else if (toCnt == TW'(TIMEOUT - 1)) begin
               nextState = DONE;
               errNext   = 1'b1;
               rdataNext = '0;
            end else begin
               toNext = toCnt + 1'b1;
            end
         end
         DONE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign bus.mem_rd    = inAcc & ~isWr;
   assign bus.mem_wr    = inAcc & isWr;
   assign bus.mem_addr  = inAcc ? addrQ : '0;
   assign bus.mem_wdata = inAcc ? wdataQ : '0;
   assign bus.if_done   = (state == DONE) & ~gntD;
   assign bus.d_done    = (state == DONE) & gntD;
   assign bus.rdata     = rdataQ;
   assign bus.err       = errQ;
   assign bus.stall     = dReq & ~bus.d_done;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a
// transaction-level reference model.
module tb_memory_arbiter;
   localparam int AW   = 16;
   localparam int DW   = 16;
   localparam int SMAX = 4;
   localparam int TMO  = 15;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   memory_arbiter #(
      .ADDR_W(AW), .DATA_W(DW),
      .STARVE_MAX(SMAX), .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: one outstanding access, described by what
   // was granted, how long it has waited, and whether it finished
   bit              mBusy = 0, mFin = 0, mD = 0, mWr = 0, mErr = 0;
   logic [AW-1:0]   mAddr = '0;
   logic [DW-1:0]   mWdata = '0, mRdata = '0;
   int              mWait = 0, mStarve = 0;

   initial begin : cmp
      bit acc;
      bit dFin;
      forever begin
         @(negedge clk);
         acc  = mBusy && !mFin;
         dFin = mFin && mD;
         check("mem_rd", bus.mem_rd, acc && !mWr);
         check("mem_wr", bus.mem_wr, acc && mWr);
         check("mem_addr", bus.mem_addr, acc ? mAddr : 0);
         check("mem_wdata", bus.mem_wdata, acc ? mWdata : 0);
         check("if_done", bus.if_done, mFin && !mD);
         check("d_done", bus.d_done, dFin);
         check("stall", bus.stall,
               (bus.d_rd || bus.d_wr) && !dFin);
         check("rdata", bus.rdata, mRdata);
         check("err", bus.err, mErr);
         if (rst) begin
            mBusy = 0; mFin = 0; mWait = 0; mStarve = 0;
            mRdata = '0; mErr = 0;
         end else if (mFin) begin
            mFin = 0; mBusy = 0;
         end else if (mBusy) begin
            if (bus.mem_ready) begin
               if (!mWr) mRdata = bus.mem_rdata;
               mFin = 1;
            end else begin
               mWait++;
               if (mWait == TMO) begin
                  mFin = 1; mErr = 1; mRdata = '0;
               end
            end
         end else begin
            if (!bus.if_req) mStarve = 0;
            if ((bus.d_rd || bus.d_wr) &&
                !(bus.if_req && mStarve == SMAX)) begin
               mBusy = 1; mD = 1; mWr = bus.d_wr; mWait = 0;
               mAddr = bus.d_addr; mWdata = bus.d_wdata;
               if (bus.d_rd && bus.d_wr) mErr = 1;
               if (bus.if_req) mStarve++;
            end else if (bus.if_req) begin
               mBusy = 1; mD = 0; mWr = 0; mWait = 0;
               mAddr = bus.if_addr; mWdata = '0; mStarve = 0;
            end
         end
      end
   end

   initial begin : stim
      int        acc;
      int        n;
      int        longStall;
      bit        seen;
      bit        ifD, dD;
      int        r;
      logic [5:0] seq;
      rst = 1;
      bus.if_req = 0; bus.if_addr = '0;
      bus.d_rd = 0; bus.d_wr = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check("rst_err", bus.err, 0);
      check("rst_rdata", bus.rdata, 0);
      tick();

      // single fetch, ready in the first access cycle
      bus.if_req = 1; bus.if_addr = 16'h0010;
      bus.mem_ready = 1; bus.mem_rdata = 16'hABCD;
      #1 check("f_idle_rd", bus.mem_rd, 0);
      tick();
      check("f_rd", bus.mem_rd, 1);
      check("f_addr", bus.mem_addr, 16'h0010);
      tick();
      check("f_done", bus.if_done, 1);
      check("f_rdata", bus.rdata, 16'hABCD);
      bus.if_req = 0;
      tick();
      check("f_idle_done", bus.if_done, 0);
      check("f_idle_rd2", bus.mem_rd, 0);

      // read+write collision -> write and error
      bus.d_rd = 1; bus.d_wr = 1;
      bus.d_addr = 16'h0030; bus.d_wdata = 16'h5555;
      bus.mem_rdata = 16'h1111;
      #1 check("c_err0", bus.err, 0);
      tick();
      check("c_wr", bus.mem_wr, 1);
      check("c_rd", bus.mem_rd, 0);
      check("c_wdata", bus.mem_wdata, 16'h5555);
      check("c_err", bus.err, 1);
      tick();
      check("c_done", bus.d_done, 1);
      check("c_rdata_kept", bus.rdata, 16'hABCD);
      bus.d_rd = 0; bus.d_wr = 0;
      tick();
      rst = 1;
      tick();
      check("r_err", bus.err, 0);
      check("r_rdata", bus.rdata, 0);
      rst = 0;
      tick();

      // simultaneous fetch and write: data first
      bus.if_req = 1; bus.if_addr = 16'h0040;
      bus.d_wr = 1; bus.d_addr = 16'h0020;
      bus.d_wdata = 16'h1234; bus.mem_rdata = 16'h7777;
      #1 check("s_stall0", bus.stall, 1);
      tick();
      check("s_wr", bus.mem_wr, 1);
      check("s_addr", bus.mem_addr, 16'h0020);
      check("s_wdata", bus.mem_wdata, 16'h1234);
      check("s_stall1", bus.stall, 1);
      tick();
      check("s_ddone", bus.d_done, 1);
      check("s_stall2", bus.stall, 0);
      bus.d_wr = 0;
      tick();
      check("s_idle_rd", bus.mem_rd, 0);
      tick();
      check("s_frd", bus.mem_rd, 1);
      check("s_faddr", bus.mem_addr, 16'h0040);
      tick();
      check("s_fdone", bus.if_done, 1);
      check("s_frdata", bus.rdata, 16'h7777);
      bus.if_req = 0;
      tick();

      // timeout on a read
      bus.mem_ready = 0; bus.d_rd = 1; bus.d_addr = 16'h0050;
      acc = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (bus.mem_rd) acc++;
         if (bus.d_done) seen = 1;
      end
      check("t_done", seen, 1);
      check("t_cycles", acc, TMO);
      check("t_rdata", bus.rdata, 0);
      check("t_err", bus.err, 1);
      bus.d_rd = 0;
      tick();
      tick();
      check("t_sticky", bus.err, 1);

      // reset in the middle of a write
      bus.d_wr = 1; bus.d_addr = 16'h0060; bus.d_wdata = 16'h0F0F;
      tick();
      check("m_wr", bus.mem_wr, 1);
      rst = 1;
      tick();
      check("m_wr_rst", bus.mem_wr, 0);
      check("m_done_rst", bus.d_done, 0);
      check("m_err_rst", bus.err, 0);
      rst = 0; bus.d_wr = 0;
      tick();
      check("m_done_after", bus.d_done, 0);

      // starvation bound with both requests held
      bus.mem_ready = 1;
      bus.if_req = 1; bus.if_addr = 16'h0080;
      bus.d_rd = 1; bus.d_addr = 16'h0090;
      seq = '0; n = 0;
      for (int i = 0; i < 40 && n < 6; i++) begin
         tick();
         if (bus.d_done) begin seq = {seq[4:0], 1'b1}; n++; end
         else if (bus.if_done) begin seq = {seq[4:0], 1'b0}; n++; end
      end
      check("v_count", n, 6);
      check("v_order", seq, 6'b111101);
      bus.if_req = 0; bus.d_rd = 0;
      tick();
      tick();

      // randomized traffic
      longStall = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ifD = bus.if_done;
         dD  = bus.d_done;
         @(posedge clk);
         #1;
         if (bus.if_req) begin
            if (ifD || $urandom_range(0, 49) == 0) bus.if_req = 0;
         end else if ($urandom_range(0, 2) == 0) begin
            bus.if_req = 1; bus.if_addr = AW'($urandom);
         end
         if (bus.d_rd || bus.d_wr) begin
            if (dD || $urandom_range(0, 49) == 0) begin
               bus.d_rd = 0; bus.d_wr = 0;
            end
         end else if ($urandom_range(0, 1) == 0) begin
            r = $urandom_range(0, 19);
            bus.d_rd = (r < 10);
            bus.d_wr = (r >= 9);
            bus.d_addr = AW'($urandom);
            bus.d_wdata = DW'($urandom);
         end
         if (longStall > 0) begin
            bus.mem_ready = 0;
            longStall--;
         end else begin
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 149) == 0) longStall = 20;
         end
         bus.mem_rdata = DW'($urandom);
         rst = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 16, address width; DATA_W, default 16, data width; STARVE_MAX, default 4, consecutive data grants allowed while fetch waits; TIMEOUT, default 15, max ACC cycles without mem_ready.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  fetch read request, level, held until if_done.
REQ-005 if_addr  in  ADDR_W  fetch address, stable while if_req high.
REQ-006 d_rd / d_wr  in  1 each  data read / write request (decoded MemR / MemWR), level, held until d_done.
REQ-007 d_addr, d_wdata  in  ADDR_W, DATA_W  data address and write data, stable while request high.
REQ-008 mem_ready  in  1  memory completes the current access this cycle.
REQ-009 mem_rdata  in  DATA_W  memory read data, valid when mem_ready high.
REQ-010 mem_addr, mem_wdata  out  ADDR_W, DATA_W  shared memory port address and write data.
REQ-011 mem_rd, mem_wr  out  1 each  memory strobes.
REQ-012 if_done, d_done  out  1 each  one-cycle completion pulses.
REQ-013 rdata  out  DATA_W  registered read data, valid with if_done or d_done.
REQ-014 stall  out  1  high while any data request is pending and not yet done.
REQ-015 err  out  1  sticky error flag.

Function
REQ-016 The block SHALL implement FSM states IDLE, ACC_IF, ACC_D, DONE.
REQ-017 IDLE: if d_rd|d_wr and not starved, go to ACC_D; else if if_req, go to ACC_IF; else stay.
REQ-018 Starved SHALL mean if_req high and starve_cnt == STARVE_MAX; starve_cnt increments on each ACC_D entry while if_req is high, and clears on ACC_IF entry or when if_req is low in IDLE.
REQ-019 ACC_x: mem_addr/mem_wdata driven from the granted requester; mem_rd=1 for fetch or data read; mem_wr=1 for data write; strobes held for the whole state.
REQ-020 d_rd and d_wr both high SHALL be treated as a write and SHALL set err.
REQ-021 ACC_x with mem_ready=1 SHALL go to DONE, capturing mem_rdata into rdata for reads; rdata SHALL be unchanged for writes.
REQ-022 A timeout counter SHALL clear on ACC entry and count each ACC cycle without mem_ready; on reaching TIMEOUT, go to DONE, set err, and set rdata to 0.
REQ-023 DONE: pulse the done output of the granted requester for exactly one cycle, strobes 0, then go to IDLE unconditionally.
REQ-024 Latency: request seen in IDLE at cycle N, strobe at N+1, and mem_ready at N+k gives done at N+k+1; minimum 3 cycles per access including IDLE.
REQ-025 Outside ACC states, mem_rd, mem_wr, mem_addr and mem_wdata SHALL be 0.
REQ-026 stall = (d_rd|d_wr) & ~d_done, combinational.
REQ-027 A request dropped mid-ACC SHALL be ignored; the access completes normally.
REQ-028 Requests arriving during ACC/DONE SHALL wait until IDLE; no request is lost while held.

Reset
REQ-029 Reset SHALL force state IDLE, starve_cnt=0, timeout counter=0, rdata=0, err=0, if_done=d_done=0, and all strobes 0, overriding any in-flight access with no done pulse.

Verification
REQ-030 Single fetch: if_req, if_addr=0x0010, mem_ready one cycle after strobe, mem_rdata=0xABCD -> mem_rd at N+1, if_done and rdata=0xABCD at N+2, IDLE at N+3.
REQ-031 Simultaneous if_req and d_wr (d_addr=0x0020, d_wdata=0x1234) -> data written first with mem_wr=1, stall high until d_done, then fetch served.
REQ-032 Starvation: d_rd continuously re-asserted with if_req held -> exactly STARVE_MAX (4) data accesses, then one fetch, then data resumes.
REQ-033 Timeout: d_rd with mem_ready held 0 -> DONE after 15 ACC cycles, d_done pulses, rdata=0, err=1 until rst.
REQ-034 Reset mid-ACC_D (write in progress) -> next cycle mem_wr=0, state IDLE, no d_done, err=0.
REQ-035 d_rd=d_wr=1 -> write performed, err=1.
